// File: rtl/radix8_pp_gen.sv
// Two-stage partial-product generator for the factored radix-8 8x8 unsigned multiplier.
// Stage 1 registers A, the three B digits and the hard multiples; stage 2 selects one multiple per digit.
module radix8_pp_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic        out_valid,
  output logic [15:0] P1,
  output logic [12:0] P2,
  output logic [9:0]  P3
);

  // Handshake: in_valid qualifies a_in/b_in at an edge with stall=0; an edge with
  // stall=1 freezes every register and drops whatever is presented, so the sender
  // holds data until stall=0. out_valid qualifies P1..P3; bubbles carry zero.

  logic        v1_q, v1_d;
  logic [7:0]  a1_q, a1_d;
  logic [2:0]  d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [9:0]  m3_q, m3_d;
  logic [10:0] m5_q, m5_d, m7_q, m7_d;

  logic        v2_q, v2_d;
  logic [15:0] p1_q, p1_d;
  logic [12:0] p2_q, p2_d;
  logic [9:0]  p3_q, p3_d;

  logic [10:0] a_ext;
  logic [10:0] sel0, sel1, sel2;

  assign a_ext = {3'b000, a_in};

  always_comb begin
    v1_d = in_valid;
    a1_d = a_in;
    d0_d = b_in[2:0];
    d1_d = b_in[5:3];
    d2_d = {1'b0, b_in[7:6]};
    m3_d = 10'((a_ext << 1) + a_ext);
    m5_d = (a_ext << 2) + a_ext;
    m7_d = (a_ext << 3) - a_ext;
  end

  function automatic logic [10:0] sel_mult(input logic [2:0] d, input logic [7:0] a,
                                           input logic [9:0] m3, input logic [10:0] m5,
                                           input logic [10:0] m7);
    logic [10:0] r;
    r = 11'd0;
    case (d)
      3'd0: r = 11'd0;
      3'd1: r = {3'b000, a};
      3'd2: r = {2'b00, a, 1'b0};
      3'd3: r = {1'b0, m3};
      3'd4: r = {1'b0, a, 2'b00};
      3'd5: r = m5;
      3'd6: r = {m3, 1'b0};
      default: r = m7;
    endcase
    return r;
  endfunction

  always_comb begin
    sel0 = sel_mult(d0_q, a1_q, m3_q, m5_q, m7_q);
    sel1 = sel_mult(d1_q, a1_q, m3_q, m5_q, m7_q);
    sel2 = sel_mult(d2_q, a1_q, m3_q, m5_q, m7_q);
    v2_d = v1_q;
    p1_d = '0;
    p2_d = '0;
    p3_d = '0;
    if (v1_q) begin
      p1_d = {5'b0, sel0};
      p2_d = {2'b0, sel1};
      // d2 never exceeds 3, so the top bit of sel2 is always zero.
      p3_d = sel2[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      m3_q <= '0;
      m5_q <= '0;
      m7_q <= '0;
      v2_q <= 1'b0;
      p1_q <= '0;
      p2_q <= '0;
      p3_q <= '0;
    end else if (!stall) begin
      v1_q <= v1_d;
      a1_q <= a1_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      m3_q <= m3_d;
      m5_q <= m5_d;
      m7_q <= m7_d;
      v2_q <= v2_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      p3_q <= p3_d;
    end
  end

  assign out_valid = v2_q;
  assign P1        = p1_q;
  assign P2        = p2_q;
  assign P3        = p3_q;

endmodule
